// File: rtl/configurable_division.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | configurable_division: signed restoring divider. Runs one 16-bit lane or |
// | one or two 8-bit lanes, one quotient bit per lane per CALC cycle.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module configurable_division (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        enable_i,
  input  logic [1:0]  cm_i,
  input  logic [15:0] dividend_i,
  input  logic [15:0] divisor_i,
  output logic [15:0] quotient_o,
  output logic [15:0] remainder_o,
  output logic        data_valid_o,
  output logic        busy_o,
  output logic [1:0]  div_by_zero_o
);

  localparam logic [1:0] c_s_idle = 2'd0;
  localparam logic [1:0] c_s_calc = 2'd1;
  localparam logic [1:0] c_s_fix  = 2'd2;

  logic [1:0]  r_state;
  logic [3:0]  r_count;
  logic        r_wide;
  logic        r_dual;
  logic [15:0] r_dend;
  logic [15:0] r_dsor;

  // 16-bit engine: partial remainder, shifting dividend/quotient, divisor magnitude
  logic [16:0] r_wa;
  logic [15:0] r_wq;
  logic [15:0] r_wd;

  // 8-bit lane engines, lane 0 = bits [7:0], lane 1 = bits [15:8]
  logic [1:0][8:0] r_la;
  logic [1:0][7:0] r_lq;
  logic [1:0][7:0] r_ld;

  logic            w_start;
  logic            w_last;
  logic [16:0]     w_wshift;
  logic            w_wge;
  logic [16:0]     w_wa_next;
  logic [15:0]     w_wq_fix;
  logic [15:0]     w_wr_fix;
  logic            w_wz;
  logic [1:0][8:0] w_la_next;
  logic [1:0][7:0] w_lq_next;
  logic [1:0][7:0] w_lq_fix;
  logic [1:0][7:0] w_lr_fix;
  logic [1:0]      w_lz;

  function automatic logic [15:0] mag16(input logic [15:0] x);
    return x[15] ? (~x + 16'd1) : x;
  endfunction

  function automatic logic [7:0] mag8(input logic [7:0] x);
    return x[7] ? (~x + 8'd1) : x;
  endfunction

  assign w_start = (r_state == c_s_idle) && enable_i;
  assign w_last  = (r_count == (r_wide ? 4'd15 : 4'd7));

  assign w_wshift  = {r_wa[15:0], r_wq[15]};
  assign w_wge     = (w_wshift >= {1'b0, r_wd});
  assign w_wa_next = w_wge ? (w_wshift - {1'b0, r_wd}) : w_wshift;

  assign w_wz     = (r_dsor == 16'd0);
  assign w_wq_fix = w_wz ? 16'hFFFF :
                    ((r_dend[15] ^ r_dsor[15]) ? (~r_wq + 16'd1) : r_wq);
  assign w_wr_fix = w_wz ? r_dend :
                    (r_dend[15] ? (~r_wa[15:0] + 16'd1) : r_wa[15:0]);

  generate
    for (genvar i = 0; i < 2; i++) begin : g_lane
      logic [8:0] w_shift;
      logic       w_ge;
      logic [7:0] w_n;
      logic [7:0] w_d;

      assign w_n          = r_dend[8*i +: 8];
      assign w_d          = r_dsor[8*i +: 8];
      assign w_shift      = {r_la[i][7:0], r_lq[i][7]};
      assign w_ge         = (w_shift >= {1'b0, r_ld[i]});
      assign w_la_next[i] = w_ge ? (w_shift - {1'b0, r_ld[i]}) : w_shift;
      assign w_lq_next[i] = {r_lq[i][6:0], w_ge};

      // Zero divisor bypasses sign correction: all-ones quotient, raw dividend back
      assign w_lz[i]     = (w_d == 8'd0);
      assign w_lq_fix[i] = w_lz[i] ? 8'hFF :
                           ((w_n[7] ^ w_d[7]) ? (~r_lq[i] + 8'd1) : r_lq[i]);
      assign w_lr_fix[i] = w_lz[i] ? w_n :
                           (w_n[7] ? (~r_la[i][7:0] + 8'd1) : r_la[i][7:0]);
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state       <= c_s_idle;
      r_count       <= 4'd0;
      r_wide        <= 1'b0;
      r_dual        <= 1'b0;
      r_dend        <= 16'd0;
      r_dsor        <= 16'd0;
      r_wa          <= 17'd0;
      r_wq          <= 16'd0;
      r_wd          <= 16'd0;
      r_la          <= '0;
      r_lq          <= '0;
      r_ld          <= '0;
      quotient_o    <= 16'd0;
      remainder_o   <= 16'd0;
      data_valid_o  <= 1'b0;
      busy_o        <= 1'b0;
      div_by_zero_o <= 2'b00;
    end else begin
      data_valid_o <= 1'b0;
      case (r_state)
        c_s_idle: begin
          if (w_start) begin
            r_state <= c_s_calc;
            r_count <= 4'd0;
            busy_o  <= 1'b1;
            r_wide  <= cm_i[1];
            r_dual  <= (cm_i == 2'b01);
            r_dend  <= dividend_i;
            r_dsor  <= divisor_i;
            r_wa    <= 17'd0;
            r_wq    <= mag16(dividend_i);
            r_wd    <= mag16(divisor_i);
            for (int i = 0; i < 2; i++) begin
              r_la[i] <= 9'd0;
              r_lq[i] <= mag8(dividend_i[8*i +: 8]);
              r_ld[i] <= mag8(divisor_i[8*i +: 8]);
            end
          end
        end
        c_s_calc: begin
          r_wa    <= w_wa_next;
          r_wq    <= {r_wq[14:0], w_wge};
          r_la    <= w_la_next;
          r_lq    <= w_lq_next;
          r_count <= r_count + 4'd1;
          if (w_last) begin
            r_state <= c_s_fix;
          end
        end
        c_s_fix: begin
          r_state      <= c_s_idle;
          busy_o       <= 1'b0;
          data_valid_o <= 1'b1;
          if (r_wide) begin
            quotient_o    <= w_wq_fix;
            remainder_o   <= w_wr_fix;
            div_by_zero_o <= {1'b0, w_wz};
          end else if (r_dual) begin
            quotient_o    <= {w_lq_fix[1], w_lq_fix[0]};
            remainder_o   <= {w_lr_fix[1], w_lr_fix[0]};
            div_by_zero_o <= w_lz;
          end else begin
            quotient_o    <= {8'd0, w_lq_fix[0]};
            remainder_o   <= {8'd0, w_lr_fix[0]};
            div_by_zero_o <= {1'b0, w_lz[0]};
          end
        end
        default: begin
          r_state <= c_s_idle;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_configurable_division.sv
`default_nettype none
// Self-checking bench for configurable_division: directed vectors, random ops
// against an integer-arithmetic reference model, reset and back-to-back cases.
module tb_configurable_division;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        enable_i;
  logic [1:0]  cm_i;
  logic [15:0] dividend_i;
  logic [15:0] divisor_i;
  logic [15:0] quotient_o;
  logic [15:0] remainder_o;
  logic        data_valid_o;
  logic        busy_o;
  logic [1:0]  div_by_zero_o;

  int checks = 0;
  int errors = 0;

  configurable_division dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .enable_i     (enable_i),
    .cm_i         (cm_i),
    .dividend_i   (dividend_i),
    .divisor_i    (divisor_i),
    .quotient_o   (quotient_o),
    .remainder_o  (remainder_o),
    .data_valid_o (data_valid_o),
    .busy_o       (busy_o),
    .div_by_zero_o(div_by_zero_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic void lane8(input logic [7:0] n, input logic [7:0] d,
                                output logic [7:0] q, output logic [7:0] r,
                                output logic z);
    int a;
    int b;
    a = int'($signed(n));
    b = int'($signed(d));
    z = 1'b0;
    if (b == 0) begin
      q = 8'hFF; r = n; z = 1'b1;
    end else if (a == -128 && b == -1) begin
      q = 8'h80; r = 8'h00;
    end else begin
      q = 8'(a / b); r = 8'(a % b);
    end
  endfunction

  function automatic void model(input logic [1:0] cm, input logic [15:0] n,
                                input logic [15:0] d, output logic [15:0] q,
                                output logic [15:0] r, output logic [1:0] z);
    int a;
    int b;
    logic [7:0] q0, r0, q1, r1;
    logic z0, z1;
    lane8(n[7:0], d[7:0], q0, r0, z0);
    lane8(n[15:8], d[15:8], q1, r1, z1);
    if (cm == 2'b00) begin
      q = {8'h00, q0}; r = {8'h00, r0}; z = {1'b0, z0};
    end else if (cm == 2'b01) begin
      q = {q1, q0}; r = {r1, r0}; z = {z1, z0};
    end else begin
      a = int'($signed(n));
      b = int'($signed(d));
      z = 2'b00;
      if (b == 0) begin
        q = 16'hFFFF; r = n; z = 2'b01;
      end else if (a == -32768 && b == -1) begin
        q = 16'h8000; r = 16'h0000;
      end else begin
        q = 16'(a / b); r = 16'(a % b);
      end
    end
  endfunction

  // Starts one op from IDLE (called #1 after an edge), scrambles the inputs
  // after capture and waits a bounded number of edges for the strobe.
  task automatic run_op(input logic [1:0] cm, input logic [15:0] n, input logic [15:0] d,
                        output logic [15:0] q, output logic [15:0] r, output logic [1:0] z,
                        output int lat, output int busy_bad);
    cm_i = cm; dividend_i = n; divisor_i = d; enable_i = 1'b1;
    @(posedge clk_i); #1;
    enable_i = 1'b0;
    cm_i = 2'($urandom); dividend_i = 16'($urandom); divisor_i = 16'($urandom);
    lat = 0; busy_bad = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk_i); #1;
      if (data_valid_o === 1'b1) begin
        lat = k;
        break;
      end
      if (busy_o !== 1'b1) busy_bad++;
    end
    if (lat != 0 && busy_o !== 1'b0) busy_bad++;
    q = quotient_o; r = remainder_o; z = div_by_zero_o;
  endtask

  task automatic test_reset;
    reset_i = 1'b1; enable_i = 1'b1; cm_i = 2'b10;
    dividend_i = 16'd100; divisor_i = 16'd7;
    repeat (3) @(posedge clk_i);
    #1;
    checks++;
    if ({quotient_o, remainder_o, data_valid_o, busy_o, div_by_zero_o} !== 36'd0) begin
      errors++;
      $display("FAIL reset_state: got q=%h r=%h v=%b b=%b z=%b, want all zero",
               quotient_o, remainder_o, data_valid_o, busy_o, div_by_zero_o);
    end
    reset_i = 1'b0; enable_i = 1'b0;
    @(posedge clk_i); #1;
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_priority: got busy=%b, want 0", busy_o);
    end
  endtask

  task automatic test_directed;
    logic [1:0]  tcm [6] = '{2'b10, 2'b01, 2'b00, 2'b01, 2'b10, 2'b10};
    logic [15:0] tn  [6] = '{16'h1BF7, 16'h64F9, 16'hAB80, 16'h1234, 16'h1234, 16'h8000};
    logic [15:0] td  [6] = '{16'hF2BA, 16'h0702, 16'h12FF, 16'h0000, 16'h0000, 16'hFFFF};
    logic [15:0] eq  [6] = '{16'hFFFE, 16'h0EFD, 16'h0080, 16'hFFFF, 16'hFFFF, 16'h8000};
    logic [15:0] er  [6] = '{16'h016B, 16'h02FF, 16'h0000, 16'h1234, 16'h1234, 16'h0000};
    logic [1:0]  ez  [6] = '{2'b00, 2'b00, 2'b00, 2'b11, 2'b01, 2'b00};
    logic [15:0] q, r;
    logic [1:0]  z;
    int lat, bb, elat;
    for (int i = 0; i < 6; i++) begin
      run_op(tcm[i], tn[i], td[i], q, r, z, lat, bb);
      elat = tcm[i][1] ? 17 : 9;
      checks++;
      if (q !== eq[i] || r !== er[i] || z !== ez[i] || lat != elat || bb != 0) begin
        errors++;
        $display("FAIL directed_%0d: got q=%h r=%h z=%b lat=%0d busy_err=%0d, want q=%h r=%h z=%b lat=%0d busy_err=0",
                 i, q, r, z, lat, bb, eq[i], er[i], ez[i], elat);
      end
    end
  endtask

  task automatic test_hold;
    logic [15:0] q, r, mq, mr;
    logic [1:0]  z, mz;
    int lat, bb, bad;
    run_op(2'b01, 16'h9C05, 16'hFB03, q, r, z, lat, bb);
    model(2'b01, 16'h9C05, 16'hFB03, mq, mr, mz);
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk_i); #1;
      if (data_valid_o !== 1'b0 || busy_o !== 1'b0 || quotient_o !== mq ||
          remainder_o !== mr || div_by_zero_o !== mz) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL hold_outputs: got %0d bad idle cycles (q=%h r=%h), want 0 (q=%h r=%h)",
               bad, quotient_o, remainder_o, mq, mr);
    end
  endtask

  task automatic test_random;
    logic [1:0]  cm;
    logic [15:0] n, d, q, r, mq, mr;
    logic [1:0]  z, mz;
    int lat, bb, elat, sel;
    for (int i = 0; i < 80; i++) begin
      cm = 2'($urandom); n = 16'($urandom); d = 16'($urandom);
      sel = $urandom_range(0, 9);
      if (sel == 0) d[7:0] = 8'h00;
      if (sel == 1) d[15:8] = 8'h00;
      if (sel == 2) begin n = 16'h8080; d = 16'hFFFF; end
      if (sel == 3) d = 16'h0000;
      run_op(cm, n, d, q, r, z, lat, bb);
      model(cm, n, d, mq, mr, mz);
      elat = cm[1] ? 17 : 9;
      checks++;
      if (q !== mq || r !== mr || z !== mz || lat != elat || bb != 0) begin
        errors++;
        $display("FAIL random_%0d cm=%b n=%h d=%h: got q=%h r=%h z=%b lat=%0d busy_err=%0d, want q=%h r=%h z=%b lat=%0d",
                 i, cm, n, d, q, r, z, lat, bb, mq, mr, mz, elat);
      end
    end
  endtask

  task automatic test_reset_mid_op;
    logic [15:0] q, r;
    logic [1:0]  z;
    int lat, bb, strobes;
    cm_i = 2'b10; dividend_i = 16'h7FFF; divisor_i = 16'h0003; enable_i = 1'b1;
    @(posedge clk_i); #1;
    enable_i = 1'b0;
    repeat (4) @(posedge clk_i);
    #1;
    reset_i = 1'b1;
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    checks++;
    if ({quotient_o, remainder_o, data_valid_o, busy_o, div_by_zero_o} !== 36'd0) begin
      errors++;
      $display("FAIL reset_mid_op: got q=%h r=%h v=%b b=%b z=%b, want all zero",
               quotient_o, remainder_o, data_valid_o, busy_o, div_by_zero_o);
    end
    strobes = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk_i); #1;
      if (data_valid_o !== 1'b0 || busy_o !== 1'b0) strobes++;
    end
    checks++;
    if (strobes != 0) begin
      errors++;
      $display("FAIL reset_abort: got %0d cycles with valid/busy, want 0", strobes);
    end
    run_op(2'b10, 16'd100, 16'd7, q, r, z, lat, bb);
    checks++;
    if (q !== 16'h000E || r !== 16'h0002 || z !== 2'b00 || lat != 17) begin
      errors++;
      $display("FAIL after_reset_op: got q=%h r=%h z=%b lat=%0d, want q=000e r=0002 z=00 lat=17",
               q, r, z, lat);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] n1, d1, n2, d2, q1, r1, q2, r2;
    logic [1:0]  z1, z2;
    int lat1, gap;
    n1 = 16'($urandom); d1 = 16'($urandom) | 16'h0001;
    n2 = 16'($urandom); d2 = 16'($urandom) | 16'h0100;
    model(2'b10, n1, d1, q1, r1, z1);
    model(2'b10, n2, d2, q2, r2, z2);
    cm_i = 2'b10; dividend_i = n1; divisor_i = d1; enable_i = 1'b1;
    @(posedge clk_i); #1;
    dividend_i = n2; divisor_i = d2;
    lat1 = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk_i); #1;
      if (data_valid_o === 1'b1) begin lat1 = k; break; end
    end
    checks++;
    if (quotient_o !== q1 || remainder_o !== r1 || lat1 != 17) begin
      errors++;
      $display("FAIL b2b_op1: got q=%h r=%h lat=%0d, want q=%h r=%h lat=17",
               quotient_o, remainder_o, lat1, q1, r1);
    end
    gap = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk_i); #1;
      if (k == 1) begin
        enable_i = 1'b0;
        dividend_i = 16'($urandom); divisor_i = 16'($urandom); cm_i = 2'($urandom);
      end
      if (data_valid_o === 1'b1) begin gap = k; break; end
    end
    checks++;
    if (quotient_o !== q2 || remainder_o !== r2 || div_by_zero_o !== z2 || gap != 18) begin
      errors++;
      $display("FAIL b2b_op2: got q=%h r=%h z=%b gap=%0d, want q=%h r=%h z=%b gap=18",
               quotient_o, remainder_o, div_by_zero_o, gap, q2, r2, z2);
    end
  endtask

  initial begin
    reset_i = 1'b1; enable_i = 1'b0; cm_i = 2'b00;
    dividend_i = 16'd0; divisor_i = 16'd0;
    test_reset;
    test_directed;
    test_hold;
    test_random;
    test_reset_mid_op;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
